// File: rtl/memc_pkg.sv
// memc shared definitions: one-hot state indices/encodings
// and read/write opcode constants for memc and its initiator.
package memc_pkg;

  localparam int S_IDLE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_ACK   = 2;
  localparam int S_WAIT  = 3;
  localparam int S_RESP  = 4;
  localparam int S_ERROR = 5;
  localparam int ST_W    = 6;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 6'b000001,
    ST_ISSUE = 6'b000010,
    ST_ACK   = 6'b000100,
    ST_WAIT  = 6'b001000,
    ST_RESP  = 6'b010000,
    ST_ERROR = 6'b100000
  } state_e;

endpackage

// File: rtl/memc_initiator.sv
// memc bus initiator: core req/resp (valid/ready) to memc strobes.
// One access in flight; sticky busy-timeout and missing-ack errors.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*  : core request (valid/ready, we, addr, wdata)
//   resp_* : held response (valid/ready, rdata, err)
//   mem_*  : memc addr, read/write strobes, wdata, busy, rdata
//   err_timeout, err_proto : sticky until reset
module memc_initiator
  import memc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout,
  output logic              err_proto
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic              eto_q, eto_d;
  logic              epr_q, epr_d;

  logic in_flight;
  logic strobe;

  // reset gating keeps every output low while reset is held
  assign req_ready = reset & state_q[S_IDLE]
                   & ~eto_q & ~epr_q;

  assign in_flight = state_q[S_ISSUE]
                   | state_q[S_ACK]
                   | state_q[S_WAIT];

  // strobe only fires in ISSUE once memc is free
  assign strobe       = state_q[S_ISSUE] & ~mem_busy;
  assign mem_read_en  = strobe & (we_q == OP_RD);
  assign mem_write_en = strobe & (we_q == OP_WR);
  assign mem_addr     = in_flight ? addr_q : '0;
  assign mem_wdata    = in_flight ? wdata_q : '0;

  assign resp_valid  = state_q[S_RESP];
  assign resp_rdata  = resp_valid ? rdata_q : '0;
  assign resp_err    = resp_valid & rerr_q;
  assign err_timeout = eto_q;
  assign err_proto   = epr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    eto_d   = eto_q;
    epr_d   = epr_q;
    unique case (1'b1)
      state_q[S_IDLE]: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          rdata_d = '0;
          rerr_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      state_q[S_ISSUE]: begin
        if (!mem_busy) state_d = ST_ACK;
      end
      state_q[S_ACK]: begin
        if (mem_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          epr_d   = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      state_q[S_WAIT]: begin
        if (!mem_busy) begin
          rdata_d = (we_q == OP_RD) ? mem_rdata : '0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          eto_d   = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      state_q[S_RESP]: begin
        if (resp_ready)
          state_d = (eto_q || epr_q) ? ST_ERROR
                                     : ST_IDLE;
      end
      state_q[S_ERROR]: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      eto_q   <= 1'b0;
      epr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      eto_q   <= eto_d;
      epr_q   <= epr_d;
    end
  end

endmodule

// File: tb/tb_memc_initiator.sv
// Directed bench for memc_initiator: BIST stall, write, read,
// held response, missing ack, busy timeout and async reset.
module tb_memc_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [7:0]  mem_wdata;
  logic        mem_busy;
  logic [7:0]  mem_rdata;
  logic        err_timeout;
  logic        err_proto;

  int total = 0;
  int bad   = 0;

  memc_initiator #(
    .ADDR_W (16),
    .DATA_W (8),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_wdata   (mem_wdata),
    .mem_busy    (mem_busy),
    .mem_rdata   (mem_rdata),
    .err_timeout (err_timeout),
    .err_proto   (err_proto)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    mem_busy   = 1'b0;
    mem_rdata  = '0;
    repeat (3) step();
    reset = 1'b1;
    #1;
  endtask

  // Leaves the DUT in ISSUE with busy low, just after the accept edge.
  task automatic send_req(input logic we,
                          input logic [15:0] a,
                          input logic [7:0] d);
    int n;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    mem_busy  = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("req_accept", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    #1;
  endtask

  // memc model: busy for nbusy cycles starting the cycle after the
  // strobe, then one busy-low cycle carrying rd; ends in RESP.
  task automatic serve(input int nbusy,
                       input logic [7:0] rd,
                       input logic we,
                       input logic [15:0] a,
                       input logic [7:0] wd);
    int xs;
    chk("stb_rd", {31'd0, mem_read_en}, {31'd0, ~we});
    chk("stb_wr", {31'd0, mem_write_en}, {31'd0, we});
    chk("stb_addr", {16'd0, mem_addr}, {16'd0, a});
    if (we) chk("stb_wdata", {24'd0, mem_wdata}, {24'd0, wd});
    xs = 0;
    for (int k = 0; k < nbusy; k++) begin
      step();
      mem_busy  = 1'b1;
      mem_rdata = 8'h00;
      #1;
      xs += int'(mem_read_en) + int'(mem_write_en);
    end
    step();
    mem_busy  = 1'b0;
    mem_rdata = rd;
    #1;
    xs += int'(mem_read_en) + int'(mem_write_en);
    step();
    mem_rdata = 8'h00;
    #1;
    chk("extra_strobe", xs, 0);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
  endtask

  initial begin
    int strobes;
    int hold_bad;
    do_reset();

    // reset state (sampled while reset still low)
    reset = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, req_ready}, 32'd0);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_err", {30'd0, err_timeout, err_proto}, 32'd0);
    reset = 1'b1;
    #1;
    chk("idle_rdy", {31'd0, req_ready}, 32'd1);

    // BIST: busy held 40 cycles, read 0x1234 must wait
    mem_busy  = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h1234;
    req_valid = 1'b1;
    strobes   = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      req_valid = 1'b0;
      #1;
      strobes += int'(mem_read_en) + int'(mem_write_en);
    end
    chk("bist_nostb", strobes, 0);
    chk("bist_rdy", {31'd0, req_ready}, 32'd0);
    chk("bist_addr", {16'd0, mem_addr}, 32'h1234);
    mem_busy = 1'b0;
    #1;
    serve(1, 8'h3C, 1'b0, 16'h1234, 8'h00);
    chk("bist_rv", {31'd0, resp_valid}, 32'd1);
    chk("bist_rd", {24'd0, resp_rdata}, 32'h3C);
    chk("bist_err", {31'd0, resp_err}, 32'd0);
    take_resp();
    chk("bist_done", {31'd0, resp_valid}, 32'd0);
    chk("idle_addr", {16'd0, mem_addr}, 32'd0);

    // write 0x00FF <= 0xA5, busy 3 cycles
    send_req(1'b1, 16'h00FF, 8'hA5);
    serve(3, 8'hEE, 1'b1, 16'h00FF, 8'hA5);
    chk("wr_rv", {31'd0, resp_valid}, 32'd1);
    chk("wr_err", {31'd0, resp_err}, 32'd0);
    chk("wr_rd", {24'd0, resp_rdata}, 32'd0);
    take_resp();
    chk("wr_idle", {31'd0, req_ready}, 32'd1);

    // read 0x8000 returns 0x5A; response held 10 cycles
    send_req(1'b0, 16'h8000, 8'h00);
    serve(2, 8'h5A, 1'b0, 16'h8000, 8'h00);
    chk("rd_rv", {31'd0, resp_valid}, 32'd1);
    chk("rd_data", {24'd0, resp_rdata}, 32'h5A);
    chk("rd_err", {31'd0, resp_err}, 32'd0);
    req_we    = 1'b1;
    req_addr  = 16'h4444;
    req_valid = 1'b1;
    hold_bad  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!resp_valid || resp_rdata != 8'h5A ||
          req_ready || mem_read_en || mem_write_en)
        hold_bad++;
    end
    chk("hold", hold_bad, 0);
    req_valid = 1'b0;
    take_resp();
    chk("hold_rel", {31'd0, resp_valid}, 32'd0);
    chk("hold_rdy", {31'd0, req_ready}, 32'd1);

    // busy never raised after strobe -> protocol error
    send_req(1'b0, 16'h0042, 8'h00);
    serve(0, 8'h99, 1'b0, 16'h0042, 8'h00);
    chk("pr_rv", {31'd0, resp_valid}, 32'd1);
    chk("pr_err", {31'd0, resp_err}, 32'd1);
    chk("pr_flag", {31'd0, err_proto}, 32'd1);
    chk("pr_rd", {24'd0, resp_rdata}, 32'd0);
    take_resp();
    req_valid = 1'b1;
    strobes   = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      strobes += int'(mem_read_en) + int'(mem_write_en);
    end
    req_valid = 1'b0;
    chk("err_rdy", {31'd0, req_ready}, 32'd0);
    chk("err_stb", strobes, 0);
    chk("err_rv", {31'd0, resp_valid}, 32'd0);
    chk("err_sticky", {31'd0, err_proto}, 32'd1);

    do_reset();
    chk("rst_pr", {31'd0, err_proto}, 32'd0);
    chk("rst_rdy2", {31'd0, req_ready}, 32'd1);

    // TIMEOUT=8: busy stuck high, error after 9th WAIT cycle
    send_req(1'b0, 16'h0100, 8'h00);
    chk("to_stb", {31'd0, mem_read_en}, 32'd1);
    step();
    mem_busy = 1'b1;
    #1;
    for (int w = 1; w <= 9; w++) begin
      step();
      if (w == 9) begin
        chk("to_pre", {31'd0, err_timeout}, 32'd0);
        chk("to_prerv", {31'd0, resp_valid}, 32'd0);
      end
    end
    step();
    chk("to_set", {31'd0, err_timeout}, 32'd1);
    chk("to_rv", {31'd0, resp_valid}, 32'd1);
    chk("to_err", {31'd0, resp_err}, 32'd1);
    chk("to_rd", {24'd0, resp_rdata}, 32'd0);
    take_resp();
    chk("to_rdy", {31'd0, req_ready}, 32'd0);

    do_reset();
    chk("rst_to", {31'd0, err_timeout}, 32'd0);

    // reset asserted while strobe is high
    send_req(1'b1, 16'h0F0F, 8'h11);
    chk("mid_stb", {31'd0, mem_write_en}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_drop", {31'd0, mem_write_en}, 32'd0);
    chk("mid_addr", {16'd0, mem_addr}, 32'd0);
    do_reset();
    chk("mid_rdy", {31'd0, req_ready}, 32'd1);
    chk("mid_rv", {31'd0, resp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
